// File: rtl/td4_prog_loader_ctrl.sv
// TD4 program store controller: 16x8 writable program memory shared by CPU fetch and a host loader.
// Optional PROG_CHECKSUM_EN keeps a running modulo-256 sum of the memory on prog_sum.
//
// state   | meaning
// RUN     | CPU fetches from memory, loader idle
// DRAIN   | CPU halted, waiting for an instruction boundary (or timeout)
// LOAD    | loader owns memory, write beats accepted
// RESTART | CPU held in reset for RST_CYCLES before resuming
module td4_prog_loader_ctrl #(
   parameter int unsigned RST_CYCLES    = 2,
   parameter int unsigned DRAIN_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] cpu_addr,
   output logic [7:0] cpu_dout,
   input  logic       cpu_idle,
   output logic       cpu_halt,
   output logic       cpu_rst,
   input  logic       ld_req,
   output logic       ld_ack,
   input  logic       ld_valid,
   output logic       ld_ready,
   input  logic [3:0] ld_addr,
   input  logic [7:0] ld_data,
   output logic [4:0] ld_count,
   output logic       drain_err,
   output logic [7:0] prog_sum
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_LOAD    = 2'd2,
      ST_RESTART = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] mem [16];
   logic [7:0] tmr;
   logic [7:0] tmr_load;
   logic       tmr_tc;
   logic       drain_to;
   logic       load_entry;
   logic       wr_en;

   assign tmr_tc     = (tmr == 8'd0);
   assign wr_en      = (state == ST_LOAD) && ld_valid;
   assign load_entry = (state == ST_DRAIN) && (state_nxt == ST_LOAD);

   always_comb begin
      state_nxt = state;
      drain_to  = 1'b0;
      tmr_load  = 8'd0;
      cpu_halt  = 1'b1;
      cpu_rst   = 1'b0;
      ld_ack    = 1'b0;
      ld_ready  = 1'b0;
      cpu_dout  = 8'h00;
      unique case (state)
         ST_RUN: begin
            cpu_halt = 1'b0;
            cpu_dout = mem[cpu_addr];
            if (ld_req) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            cpu_dout = mem[cpu_addr];
            if (!ld_req) begin
               state_nxt = ST_RUN;
            end else if (cpu_idle) begin
               state_nxt = ST_LOAD;
            end else if (tmr_tc) begin
               state_nxt = ST_LOAD;
               drain_to  = 1'b1;
            end
         end
         ST_LOAD: begin
            ld_ack   = 1'b1;
            ld_ready = 1'b1;
            if (!ld_req) state_nxt = ST_RESTART;
         end
         ST_RESTART: begin
            cpu_rst = 1'b1;
            if (tmr_tc) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
      // Timer is reloaded on every state change; terminal count at zero.
      if (state_nxt == ST_DRAIN)   tmr_load = 8'(DRAIN_TIMEOUT - 1);
      if (state_nxt == ST_RESTART) tmr_load = 8'(RST_CYCLES - 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         tmr       <= 8'd0;
         ld_count  <= 5'd0;
         drain_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) tmr <= tmr_load;
         else if (!tmr_tc)       tmr <= tmr - 8'd1;
         if (load_entry) begin
            ld_count  <= 5'd0;
            drain_err <= drain_to;
         end else if (wr_en && (ld_count != 5'd31)) begin
            ld_count <= ld_count + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      end else if (wr_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

`ifdef PROG_CHECKSUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk) begin
      if (!rst_n)     sum_q <= 8'h00;
      else if (wr_en) sum_q <= sum_q + ld_data - mem[ld_addr];
   end

   assign prog_sum = sum_q;
`else
   assign prog_sum = 8'h00;
`endif

endmodule
